// File: rtl/sdram_capture_writer.sv
// Packs 8-bit samples into 16-bit words and streams them into an SDRAM ring buffer.
// Optional SAMPLE_OFFSET_BINARY_EN inverts each sample MSB before packing.
module sdram_capture_writer #(
  parameter int ADDR_W       = 25,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 1048576,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              M100CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        sample_in,
  input  logic              sample_valid,
  input  logic              clr_overflow,
  output logic              avm_chipenable,
  output logic [ADDR_W-1:0] avm_address,
  output logic [1:0]        avm_byteenable,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] wr_pointer,
  output logic [31:0]       words_committed,
  output logic              overflow,
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(BASE_ADDR + REGION_WORDS - 1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state;

  function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef SAMPLE_OFFSET_BINARY_EN
    return {~b[7], b[6:0]};
`else
    return b;
`endif
  endfunction

  logic        half;
  logic [7:0]  lo_byte;
  logic        push;
  logic [15:0] push_word;

  assign push      = enable && sample_valid && half;
  assign push_word = {conv(sample_in), lo_byte};

  // Dropping enable clears a pending half so a stale byte never pairs up.
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      half    <= 1'b0;
      lo_byte <= 8'h00;
    end else if (!enable) begin
      half <= 1'b0;
    end else if (sample_valid) begin
      if (!half) begin
        lo_byte <= conv(sample_in);
        half    <= 1'b1;
      end else begin
        half <= 1'b0;
      end
    end
  end

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic [15:0]   head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign pop   = !empty && ((state == IDLE) || !avm_waitrequest);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge M100CLK) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge M100CLK) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A set in the same cycle as a clear must win.
  always_ff @(posedge M100CLK) begin
    if (reset)                        overflow <= 1'b0;
    else if (push && full && !pop)    overflow <= 1'b1;
    else if (clr_overflow)            overflow <= 1'b0;
  end

  logic [ADDR_W-1:0] next_ptr;

  assign next_ptr = (wr_pointer == LAST) ? FIRST : wr_pointer + 1'b1;

  always_ff @(posedge M100CLK) begin
    if (reset) begin
      state           <= IDLE;
      avm_write       <= 1'b0;
      avm_address     <= FIRST;
      avm_writedata   <= 16'h0000;
      wr_pointer      <= FIRST;
      words_committed <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            avm_writedata <= head;
            avm_address   <= wr_pointer;
            avm_write     <= 1'b1;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            wr_pointer      <= next_ptr;
            words_committed <= words_committed + 32'd1;
            if (!empty) begin
              avm_writedata <= head;
              avm_address   <= next_ptr;
            end else begin
              avm_write <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign avm_chipenable = 1'b1;
  assign avm_byteenable = 2'b11;
  assign busy           = (state == WRITE) || !empty;

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Directed bench for sdram_capture_writer with a write scoreboard.
// Expected words and addresses come from a bench-side pointer model.
module tb_sdram_capture_writer;

  localparam int AW   = 25;
  localparam int BASE = 100;
  localparam int REGW = 4;
  localparam int DEP  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [7:0]    sample_in;
  logic          sample_valid;
  logic          clr_overflow;
  logic          avm_chipenable;
  logic [AW-1:0] avm_address;
  logic [1:0]    avm_byteenable;
  logic          avm_write;
  logic [15:0]   avm_writedata;
  logic          avm_waitrequest;
  logic [AW-1:0] wr_pointer;
  logic [31:0]   words_committed;
  logic          overflow;
  logic          busy;

  sdram_capture_writer #(
    .ADDR_W(AW),
    .BASE_ADDR(BASE),
    .REGION_WORDS(REGW),
    .FIFO_DEPTH(DEP)
  ) dut (
    .M100CLK(clk),
    .reset(reset),
    .enable(enable),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .clr_overflow(clr_overflow),
    .avm_chipenable(avm_chipenable),
    .avm_address(avm_address),
    .avm_byteenable(avm_byteenable),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .wr_pointer(wr_pointer),
    .words_committed(words_committed),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [AW+15:0] sb[$];
  logic [AW-1:0] exp_ptr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic [7:0] s0,
                                       input logic [7:0] s1);
`ifdef SAMPLE_OFFSET_BINARY_EN
    return {~s1[7], s1[6:0], ~s0[7], s0[6:0]};
`else
    return {s1, s0};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    sample_in    = b;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                           input bit expect_write);
    send(lo);
    send(hi);
    if (expect_write) begin
      sb.push_back({exp_ptr, pack(lo, hi)});
      exp_ptr = (exp_ptr == AW'(BASE + REGW - 1)) ? AW'(BASE)
                                                  : exp_ptr + 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && busy; i++) tick();
    chk("drain_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic wait_write();
    for (int i = 0; i < 50 && !avm_write; i++) tick();
    chk("write_seen", avm_write, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_write", avm_write, 0);
    chk("rst_ce", avm_chipenable, 1);
    chk("rst_be", avm_byteenable, 2'b11);
    chk("rst_data", avm_writedata, 0);
    chk("rst_addr", avm_address, BASE);
    chk("rst_ptr", wr_pointer, BASE);
    chk("rst_cnt", words_committed, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    reset   = 1'b0;
    exp_ptr = AW'(BASE);
    sb.delete();
  endtask

  // Scoreboard pop on accept, plus stability check across stalls.
  logic          stall_prev = 1'b0;
  logic [AW-1:0] addr_prev;
  logic [15:0]   data_prev;
  logic [AW+15:0] e;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_write", avm_write, 1);
        chk("stall_addr", avm_address, addr_prev);
        chk("stall_data", avm_writedata, data_prev);
      end
      if (avm_write && !avm_waitrequest) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", avm_address, 0);
          chk("unexpected_write_q", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", avm_address, e[AW+15:16]);
          chk("wr_data", avm_writedata, e[15:0]);
        end
      end
      stall_prev = avm_write && avm_waitrequest;
      addr_prev  = avm_address;
      data_prev  = avm_writedata;
    end
  end

  initial begin
    enable          = 1'b0;
    sample_in       = 8'h00;
    sample_valid    = 1'b0;
    clr_overflow    = 1'b0;
    avm_waitrequest = 1'b0;
    exp_ptr         = AW'(BASE);
    do_reset();

    // Basic packing and sequential addresses
    enable = 1'b1;
    send_word(8'h11, 8'h22, 1);
    send_word(8'h33, 8'h44, 1);
    drain();
    chk("t1_ptr", wr_pointer, BASE + 2);
    chk("t1_cnt", words_committed, 2);

    // Stalled first write: held five cycles
    avm_waitrequest = 1'b1;
    send_word(8'h5C, 8'hC5, 1);
    wait_write();
    repeat (5) tick();
    chk("t2_cnt_stalled", words_committed, 2);
    avm_waitrequest = 1'b0;
    drain();
    chk("t2_cnt", words_committed, 3);

    // Wrap across a 4-word region
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 10; i++)
      send_word(8'(i * 3 + 1), 8'(8'hF0 - i), 1);
    drain();
    chk("t3_ptr", wr_pointer, BASE + 2);
    chk("t3_cnt", words_committed, 10);

    // Overflow: one word in flight, FIFO full, last word dropped
    avm_waitrequest = 1'b1;
    for (int i = 0; i < DEP + 1; i++)
      send_word(8'(8'h40 + i), 8'(8'h60 + i), 1);
    chk("t4_ovf_pre", overflow, 0);
    send_word(8'hDE, 8'hAD, 0);
    tick();
    chk("t4_ovf", overflow, 1);
    chk("t4_busy", busy, 1);
    avm_waitrequest = 1'b0;
    drain();
    chk("t4_cnt", words_committed, 10 + DEP + 1);
    chk("t4_ptr", wr_pointer, exp_ptr);
    chk("t4_ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t4_ovf_clr", overflow, 0);

    // Stale half word discarded on enable drop
    send(8'h55);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    send_word(8'hAA, 8'hBB, 1);
    drain();
    chk("t5_ptr", wr_pointer, exp_ptr);

    // MSB handling of the packed word
    send_word(8'h80, 8'h00, 1);
    drain();
    chk("t6_cnt", words_committed, 10 + DEP + 3);

    // Reset during a stalled write abandons it
    avm_waitrequest = 1'b1;
    send_word(8'h5A, 8'hA5, 0);
    wait_write();
    tick();
    do_reset();
    avm_waitrequest = 1'b0;
    repeat (4) tick();
    chk("t7_write", avm_write, 0);
    chk("t7_cnt", words_committed, 0);
    chk("t7_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
